fifo_pop_ctrl: RTL and testbench

//  Read-side controller for the router fifo: pops items through the FIFO's show-ahead read port
//  (read/empty/item_out) and forwards them on a registered valid/ready stream.

---
 rtl/fifo_rd_pkg.sv | 17 +
 rtl/fifo_pop_ctrl_skid_buf2.sv | 47 ++++
 rtl/fifo_pop_ctrl.sv | 74 +++++++
 tb/tb_fifo_pop_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the router fifo read-side controller: FSM encoding and defaults.
package fifo_rd_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } rd_state_e;

  localparam int DEF_WIDTH   = 2;
  localparam int DEF_PKT_LEN = 4;
  localparam int DEF_CNT_W   = 16;

  // Width of a counter holding 0..n-1; a single-item packet still needs one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_pop_ctrl_skid_buf2.sv
// Two-entry valid/ready buffer (main + skid); accepts only while the skid slot is free.
module skid_buf2 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         skid_valid
);
  logic [W-1:0] skid_data;
  logic         hs;
  logic         push;

  assign in_ready = !skid_valid;
  assign hs       = out_valid & out_ready;
  assign push     = in_valid & in_ready;

  // push and skid_valid are exclusive, so skid refill and skid drain never collide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (push) begin
      if (!out_valid || hs) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (hs) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/fifo_pop_ctrl.sv
// Pops a show-ahead fifo, frames items into PKT_LEN-item packets and streams them out
// through a skid buffer; on disable it finishes the open packet before going idle.
module fifo_pop_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PKT_LEN = DEF_PKT_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_item,
  output logic             fifo_read,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);
  localparam int              PC_W     = cnt_bits(PKT_LEN);
  localparam logic [PC_W-1:0] LAST_POS = PC_W'(PKT_LEN - 1);

  rd_state_e       state;
  logic [PC_W-1:0] pop_cnt;
  logic            pop_allowed;
  logic            at_last;
  logic            sb_in_ready;
  logic            skid_valid;
  logic [WIDTH:0]  sb_out;

  assign pop_allowed = ((state == ST_ACTIVE) && enable) || (state == ST_DRAIN);
  assign fifo_read   = pop_allowed & !fifo_empty & sb_in_ready;
  assign at_last     = (pop_cnt == LAST_POS);

  // last tag travels with the item as the buffer's top bit
  skid_buf2 #(.W(WIDTH + 1)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (fifo_read),
    .in_ready   (sb_in_ready),
    .in_data    ({at_last, fifo_item}),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (sb_out),
    .skid_valid (skid_valid)
  );

  assign out_last = sb_out[WIDTH];
  assign out_data = sb_out[WIDTH-1:0];
  assign busy     = (state != ST_IDLE) | out_valid | skid_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pop_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:   if (enable) state <= ST_ACTIVE;
        ST_ACTIVE: if (!enable) state <= (pop_cnt == '0) ? ST_IDLE : ST_DRAIN;
        ST_DRAIN:  if (fifo_read && at_last) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
      if (fifo_read) pop_cnt <= at_last ? '0 : pop_cnt + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pkt_count <= '0;
    else if (out_valid && out_ready && out_last) pkt_count <= pkt_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: two instances (PKT_LEN=4/CNT_W=16 and PKT_LEN=1/CNT_W=2) fed from queue fifos.
module tb_fifo_pop_ctrl;
  logic clk = 0, reset = 0, enable = 0, out_ready = 0;
  always #5 clk = ~clk;

  logic fe0 = 1, fe1 = 1;
  logic [1:0] fi0 = 0, fi1 = 0;
  logic rd0, rd1, ov0, ov1, ol0, ol1, b0, b1;
  logic [1:0] od0, od1;
  logic [15:0] pc0;
  logic [1:0] pc1;

  fifo_pop_ctrl #(.WIDTH(2), .PKT_LEN(4), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fe0), .fifo_item(fi0),
    .fifo_read(rd0), .out_valid(ov0), .out_data(od0), .out_last(ol0),
    .out_ready(out_ready), .busy(b0), .pkt_count(pc0));
  fifo_pop_ctrl #(.WIDTH(2), .PKT_LEN(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fe1), .fifo_item(fi1),
    .fifo_read(rd1), .out_valid(ov1), .out_data(od1), .out_last(ol1),
    .out_ready(out_ready), .busy(b1), .pkt_count(pc1));

  int total = 0, bad = 0;
  int fq[2][$];
  int pend[2][$];
  int st[2], pos[2], pkt[2], npop[2], nlast[2];
  int plen[2] = '{4, 1};
  int pmask[2] = '{32'hffff, 3};
  bit last_rd[2], last_hs[2];
  bit bubble = 0;
  int cyc = 0;

  function automatic logic g_rd(int d); return d == 0 ? rd0 : rd1; endfunction
  function automatic logic g_ov(int d); return d == 0 ? ov0 : ov1; endfunction
  function automatic logic g_ol(int d); return d == 0 ? ol0 : ol1; endfunction
  function automatic logic g_bsy(int d); return d == 0 ? b0 : b1; endfunction
  function automatic int g_od(int d); return d == 0 ? int'(od0) : int'(od1); endfunction
  function automatic int g_pc(int d); return d == 0 ? int'(pc0) : int'(pc1); endfunction
  function automatic logic g_fe(int d); return d == 0 ? fe0 : fe1; endfunction

  task automatic drive_fifo();
    for (int d = 0; d < 2; d++) begin
      logic e;
      logic [1:0] it;
      int h;
      e = (fq[d].size() == 0) || (bubble && cyc[0]);
      h = (fq[d].size() != 0) ? fq[d][0] : 0;
      it = h[1:0];
      if (d == 0) begin fe0 = e; fi0 = it; end
      else begin fe1 = e; fi1 = it; end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; pos[d] = 0; pkt[d] = 0;
      pend[d].delete();
    end
  endtask

  // One clock: check against the model before the edge, advance fifo and model after it.
  task automatic cycle();
    bit rs[2], hs[2], exp_rd[2];
    int got[2];
    drive_fifo();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic e;
      e = g_fe(d);
      exp_rd[d] = ((st[d] == 1 && enable) || st[d] == 2) && !e && pend[d].size() < 2;
      total++;
      if (g_rd(d) !== exp_rd[d]) begin bad++; $display("FAIL fifo_read d%0d cyc%0d: got %b want %b", d, cyc, g_rd(d), exp_rd[d]); end
      total++;
      if (g_rd(d) === 1'b1 && e) begin bad++; $display("FAIL pop_on_empty d%0d cyc%0d: got read=1 want 0", d, cyc); end
      total++;
      if (g_ov(d) !== (pend[d].size() > 0)) begin bad++; $display("FAIL out_valid d%0d cyc%0d: got %b want %b", d, cyc, g_ov(d), pend[d].size() > 0); end
      total++;
      if (g_bsy(d) !== (st[d] != 0 || pend[d].size() > 0)) begin bad++; $display("FAIL busy d%0d cyc%0d: got %b want %b", d, cyc, g_bsy(d), (st[d] != 0 || pend[d].size() > 0)); end
      total++;
      if (g_pc(d) !== pkt[d]) begin bad++; $display("FAIL pkt_count d%0d cyc%0d: got %0d want %0d", d, cyc, g_pc(d), pkt[d]); end
      rs[d] = (g_rd(d) === 1'b1) && !e;
      hs[d] = (g_ov(d) === 1'b1) && out_ready;
      got[d] = (int'(g_ol(d)) << 2) | g_od(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      bit popped_last;
      popped_last = 0;
      if (hs[d]) begin
        total++;
        if (pend[d].size() == 0) begin
          bad++; $display("FAIL spurious_beat d%0d cyc%0d: got beat %0d want none", d, cyc, got[d]);
        end else begin
          int w;
          w = pend[d].pop_front();
          if (got[d] !== w) begin bad++; $display("FAIL beat d%0d cyc%0d: got last/data %0d want %0d", d, cyc, got[d], w); end
          if (w >= 4) begin pkt[d] = (pkt[d] + 1) & pmask[d]; nlast[d]++; end
        end
      end
      if (rs[d]) begin
        int v;
        v = fq[d].pop_front();
        popped_last = (pos[d] == plen[d] - 1);
        pend[d].push_back(v | (popped_last ? 4 : 0));
        pos[d] = (pos[d] + 1) % plen[d];
        npop[d]++;
      end
      case (st[d])
        0: if (enable) st[d] = 1;
        1: if (!enable) st[d] = (pos[d] == 0) ? 0 : 2;
        default: if (exp_rd[d] && popped_last) st[d] = 0;
      endcase
      last_rd[d] = rs[d];
      last_hs[d] = hs[d];
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    #2 reset = 1;
    #1;
    total++; if (ov0 !== 0 || ov1 !== 0) begin bad++; $display("FAIL rst_out_valid: got %b%b want 00", ov0, ov1); end
    total++; if (od0 !== 0 || ol0 !== 0) begin bad++; $display("FAIL rst_out_data: got %0d/%b want 0/0", od0, ol0); end
    total++; if (rd0 !== 0 || rd1 !== 0) begin bad++; $display("FAIL rst_fifo_read: got %b%b want 00", rd0, rd1); end
    total++; if (b0 !== 0 || b1 !== 0) begin bad++; $display("FAIL rst_busy: got %b%b want 00", b0, b1); end
    total++; if (pc0 !== 0 || pc1 !== 0) begin bad++; $display("FAIL rst_pkt_count: got %0d/%0d want 0", pc0, pc1); end
    model_reset();
    @(negedge clk);
    reset = 0;
    fq[0].push_back(1);
    fq[1].push_back(2);
    run(3);
  endtask

  task automatic test_stream();
    int mask;
    mask = 0;
    fq[0].delete(); fq[1].delete();
    fq[0].push_back(1); fq[0].push_back(2); fq[0].push_back(3); fq[0].push_back(0);
    for (int i = 0; i < 4; i++) fq[1].push_back(int'($urandom_range(0, 3)));
    enable = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_rd[0]) mask |= (1 << i);
    end
    total++; if (mask !== 8'b0001_1110) begin bad++; $display("FAIL stream_read_pattern: got %b want 00011110", mask[7:0]); end
    total++; if (pc0 !== 16'd1) begin bad++; $display("FAIL stream_pkt_count: got %0d want 1", pc0); end
    enable = 0;
    run(2);
  endtask

  task automatic test_backpressure();
    int first, p0, k0;
    first = int'($urandom_range(0, 3));
    fq[0].push_back(first);
    for (int i = 0; i < 7; i++) fq[0].push_back(int'($urandom_range(0, 3)));
    p0 = npop[0]; k0 = pc0;
    out_ready = 0; enable = 1;
    run(6);
    total++; if (npop[0] - p0 != 2) begin bad++; $display("FAIL bp_pops: got %0d want 2", npop[0] - p0); end
    total++; if (od0 !== first[1:0] || ov0 !== 1'b1) begin bad++; $display("FAIL bp_hold: got %0d/%b want %0d/1", od0, ov0, first); end
    total++; if (rd0 !== 1'b0) begin bad++; $display("FAIL bp_read: got %b want 0", rd0); end
    out_ready = 1;
    run(14);
    total++; if (int'(pc0) - k0 != 2) begin bad++; $display("FAIL bp_pkt_count: got +%0d want +2", int'(pc0) - k0); end
  endtask

  task automatic test_drain();
    int p0, l0, n;
    p0 = npop[0]; l0 = nlast[0]; n = 0;
    out_ready = 1; enable = 1;
    for (int i = 0; i < 6; i++) fq[0].push_back(int'($urandom_range(0, 3)));
    while (npop[0] - p0 < 2 && n < 12) begin cycle(); n++; end
    total++; if (npop[0] - p0 != 2) begin bad++; $display("FAIL drain_start: got %0d pops want 2", npop[0] - p0); end
    enable = 0;
    run(10);
    total++; if (npop[0] - p0 != 4) begin bad++; $display("FAIL drain_pops: got %0d want 4", npop[0] - p0); end
    total++; if (fq[0].size() != 2) begin bad++; $display("FAIL drain_left: got %0d want 2", fq[0].size()); end
    total++; if (nlast[0] - l0 != 1) begin bad++; $display("FAIL drain_last: got %0d want 1", nlast[0] - l0); end
    total++; if (b0 !== 1'b0) begin bad++; $display("FAIL drain_idle: got busy %b want 0", b0); end
  endtask

  task automatic test_bubbles();
    int l0;
    l0 = nlast[0];
    for (int i = 0; i < 10; i++) fq[0].push_back(int'($urandom_range(0, 3)));
    bubble = 1; enable = 1;
    for (int i = 0; i < 70; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bubble = 0; out_ready = 1; enable = 0;
    run(4);
    total++; if (fq[0].size() != 0) begin bad++; $display("FAIL bubble_left: got %0d want 0", fq[0].size()); end
    total++; if (nlast[0] - l0 != 3) begin bad++; $display("FAIL bubble_lasts: got %0d want 3", nlast[0] - l0); end
  endtask

  task automatic test_random();
    int n;
    enable = 1;
    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < 2; d++)
        if ($urandom_range(0, 2) == 0) fq[d].push_back(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      out_ready = ($urandom_range(0, 3) != 0);
      bubble = ($urandom_range(0, 4) == 0);
      cycle();
    end
    bubble = 0; out_ready = 1; enable = 1; n = 0;
    while ((fq[0].size() != 0 || fq[1].size() != 0) && n < 200) begin cycle(); n++; end
    total++; if (fq[0].size() != 0 || fq[1].size() != 0) begin bad++; $display("FAIL random_flush: got %0d/%0d left want 0", fq[0].size(), fq[1].size()); end
    enable = 0;
    run(6);
  endtask

  task automatic test_wrap();
    int k, s;
    s = pc1; k = 0;
    for (int i = 0; i < 4; i++) fq[1].push_back(int'($urandom_range(0, 3)));
    enable = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_hs[1]) begin
        k++;
        total++; if (int'(pc1) != ((s + k) & 3)) begin bad++; $display("FAIL wrap_count beat%0d: got %0d want %0d", k, pc1, (s + k) & 3); end
      end
    end
    total++; if (k != 4) begin bad++; $display("FAIL wrap_beats: got %0d want 4", k); end
    enable = 0;
    run(2);
  endtask

  task automatic test_reset_mid();
    int reads;
    reads = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 6; i++) fq[d].push_back(int'($urandom_range(0, 3)));
    enable = 1; out_ready = 0;
    run(4);
    reset = 1;
    #1;
    total++; if (ov0 !== 0 || ov1 !== 0) begin bad++; $display("FAIL mid_out_valid: got %b%b want 00", ov0, ov1); end
    total++; if (rd0 !== 0 || rd1 !== 0) begin bad++; $display("FAIL mid_fifo_read: got %b%b want 00", rd0, rd1); end
    total++; if (b0 !== 0 || b1 !== 0) begin bad++; $display("FAIL mid_busy: got %b%b want 00", b0, b1); end
    total++; if (pc0 !== 0 || pc1 !== 0) begin bad++; $display("FAIL mid_pkt_count: got %0d/%0d want 0", pc0, pc1); end
    model_reset();
    @(negedge clk);
    reset = 0; enable = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (last_rd[0] || last_rd[1]) reads++;
    end
    total++; if (reads != 0) begin bad++; $display("FAIL mid_no_pop: got %0d reads want 0", reads); end
    enable = 1;
    run(20);
  endtask

  initial begin
    model_reset();
    for (int d = 0; d < 2; d++) begin npop[d] = 0; nlast[d] = 0; end
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_bubbles();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
